// File: rtl/fround32.sv
// fround32: two-stage FP32 normalise / round-to-nearest-even / pack stage
// fed by the multiplier mantissa product, with valid/ready handshake.
module fround32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_prod,
    input  logic        in_zero,
    input  logic        in_inf,
    input  logic        in_nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);
    logic        s1_valid_q, s1_sign_q, s1_g_q, s1_s_q, s1_zero_q, s1_inf_q, s1_nan_q;
    logic [9:0]  s1_e_q;
    logic [22:0] s1_mant_q;
    logic        s2_valid_q;
    logic [31:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic        s1_en, s2_en;
    logic [22:0] mant_d;
    logic        g_d, s_d;
    logic [9:0]  e_d;
    logic        up, ovf, unf, qnan, special;
    logic [23:0] mant_sum;
    logic [9:0]  e_r;

    assign s2_en      = !s2_valid_q | out_ready;
    assign s1_en      = !s1_valid_q | s2_en;
    assign in_ready   = s1_en & reset;
    assign out_valid  = s2_valid_q;
    assign out_result = result_q;
    assign out_flags  = flags_q;

    always_comb begin
        mant_d = in_prod[47] ? in_prod[46:24] : in_prod[45:23];
        g_d    = in_prod[47] ? in_prod[23] : in_prod[22];
        s_d    = in_prod[47] ? |in_prod[22:0] : |in_prod[21:0];
        e_d    = in_exp + {9'd0, in_prod[47]};
    end

    // mant_sum[23] is the carry out of an all-ones mantissa, which bumps the exponent
    always_comb begin
        up       = s1_g_q & (s1_s_q | s1_mant_q[0]);
        mant_sum = {1'b0, s1_mant_q} + {23'd0, up};
        e_r      = s1_e_q + {9'd0, mant_sum[23]};
        ovf      = $signed(e_r) >= 10'sd255;
        unf      = $signed(e_r) <= 10'sd0;
        qnan     = s1_nan_q | (s1_inf_q & s1_zero_q);
        special  = qnan | s1_inf_q | s1_zero_q;
        result_d = qnan      ? 32'h7FC00000 :
                   s1_inf_q  ? {s1_sign_q, 8'hFF, 23'd0} :
                   s1_zero_q ? {s1_sign_q, 31'd0} :
                   ovf       ? {s1_sign_q, 8'hFF, 23'd0} :
                   unf       ? {s1_sign_q, 31'd0} :
                               {s1_sign_q, e_r[7:0], mant_sum[22:0]};
        flags_d  = {result_d[31], result_d[30:0] == 31'd0,
                    !special & (s1_g_q | s1_s_q | ovf | unf), !special & ovf};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= 32'd0;
            flags_q    <= 4'd0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= in_valid;
                s1_sign_q  <= in_sign;
                s1_e_q     <= e_d;
                s1_mant_q  <= mant_d;
                s1_g_q     <= g_d;
                s1_s_q     <= s_d;
                s1_zero_q  <= in_zero;
                s1_inf_q   <= in_inf;
                s1_nan_q   <= in_nan;
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q <= result_d;
                    flags_q  <= flags_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_fround32.sv
// tb_fround32: directed bench for fround32 with an arithmetic rounding model
// and a queue scoreboard checked on every output transfer.
module tb_fround32;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_sign, in_zero, in_inf, in_nan;
    logic [9:0]  in_exp;
    logic [47:0] in_prod;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [35:0] exp_q[$];

    fround32 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod), .in_zero(in_zero),
        .in_inf(in_inf), .in_nan(in_nan), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Exact value is prod * 2^(exp-127-46); round the integer quotient to nearest-even.
    function automatic logic [35:0] model(bit s, int e, logic [47:0] p, bit z, bit i, bit n);
        longint unsigned q, rem, half;
        int sh, ee;
        logic [31:0] r;
        bit c, v;
        if (n || (i && z)) return {32'h7FC00000, 4'b0000};
        if (i) return {s, 8'hFF, 23'd0, s, 3'b000};
        if (z) return {s, 31'd0, s, 3'b100};
        sh   = p[47] ? 24 : 23;
        ee   = e + (p[47] ? 1 : 0);
        q    = 64'(p) >> sh;
        rem  = 64'(p) & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        c    = rem != 0;
        v    = 0;
        if (rem > half || (rem == half && q[0])) q++;
        if (q >= (64'd1 << 24)) begin
            q  = q >> 1;
            ee++;
        end
        if (ee >= 255) begin
            r = {s, 8'hFF, 23'd0};
            c = 1;
            v = 1;
        end else if (ee <= 0) begin
            r = {s, 31'd0};
            c = 1;
        end else begin
            r = {s, 8'(ee), q[22:0]};
        end
        return {r, r[31], r[30:0] == 31'd0, c, v};
    endfunction

    task automatic send(bit s, int e, logic [47:0] p, bit z, bit i, bit n);
        bit acc;
        int t = 0;
        in_sign = s; in_exp = 10'(e); in_prod = p; in_zero = z; in_inf = i; in_nan = n;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 100);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Scoreboard: transfers are decided at the next rising edge, so sample at the falling edge.
    initial begin
        bit          hold = 0;
        logic [35:0] held, e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                hold = 0;
            end else begin
                if (hold && out_valid) chk("hold_stable", {out_result, out_flags}, held);
                if (in_valid && in_ready)
                    exp_q.push_back(model(in_sign, int'($signed(in_exp)), in_prod, in_zero, in_inf, in_nan));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_result", {out_result, out_flags}, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("result", {out_result, out_flags}, e);
                    end
                end
                hold = out_valid && !out_ready;
                held = {out_result, out_flags};
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; in_valid = 0; out_ready = 0; in_sign = 0; in_exp = 0; in_prod = 0;
        in_zero = 0; in_inf = 0; in_nan = 0;
        chk("pin_1p5x2", model(0, 128, 48'h600000000000, 0, 0, 0), {32'h40400000, 4'b0000});
        chk("pin_tie_even", model(0, 127, 48'h400000400000, 0, 0, 0), {32'h3F800000, 4'b0010});
        chk("pin_tie_odd", model(0, 127, 48'h400000C00000, 0, 0, 0), {32'h3F800002, 4'b0010});
        chk("pin_carry", model(0, 127, 48'h7FFFFFC00000, 0, 0, 0), {32'h40000000, 4'b0010});
        chk("pin_ovf", model(0, 254, 48'h800000000000, 0, 0, 0), {32'h7F800000, 4'b0011});
        chk("pin_unf", model(1, 0, 48'h400000000000, 0, 0, 0), {32'h80000000, 4'b1110});
        chk("pin_inf_zero", model(0, 0, 48'h0, 1, 1, 0), {32'h7FC00000, 4'b0000});
        chk("pin_neg_inf", model(1, 0, 48'h0, 0, 1, 0), {32'hFF800000, 4'b1000});
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_result", out_result, 0);
        chk("reset_flags", out_flags, 0);
        chk("reset_ready", in_ready, 0);
        @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("ready_after_release", in_ready, 1);
        out_ready = 1;
        @(posedge clk);
        #1;
        send(0, 128, 48'h600000000000, 0, 0, 0);
        @(negedge clk);
        chk("lat_first_edge", out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_second_edge", out_valid, 1);
        chk("lat_result", out_result, 32'h40400000);
        chk("lat_flags", out_flags, 4'b0000);
        @(posedge clk);
        #1;
        send(0, 127, 48'h400000400000, 0, 0, 0);
        send(0, 127, 48'h400000C00000, 0, 0, 0);
        send(0, 127, 48'h7FFFFFC00000, 0, 0, 0);
        send(0, 254, 48'h800000000000, 0, 0, 0);
        send(1, 0, 48'h400000000000, 0, 0, 0);
        send(0, 0, 48'h0, 1, 1, 0);
        send(1, 0, 48'h0, 0, 1, 0);
        send(0, 254, 48'h7FFFFFC00000, 0, 0, 0);
        send(0, 0, 48'h800000000000, 0, 0, 0);
        send(1, -127, 48'h400000000000, 0, 0, 0);
        send(1, 5, 48'h0, 1, 0, 0);
        send(0, 5, 48'h400000000000, 0, 0, 1);
        send(1, 130, 48'h4ABCDE123457, 0, 0, 0);
        send(0, 383, 48'h800000000000, 0, 0, 0);
        send(0, 100, 48'hFFFFFFFFFFFF, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        send(0, 127, 48'h500000000000, 0, 0, 0);
        send(1, 128, 48'h480000800001, 0, 0, 0);
        in_sign = 0; in_exp = 10'd129; in_prod = 48'h6AAAAAAAAAAA; in_zero = 0; in_inf = 0; in_nan = 0;
        in_valid = 1;
        @(negedge clk);
        chk("stall_ready", in_ready, 0);
        chk("stall_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("drain_valid_%0d", i), out_valid, 1);
            @(posedge clk);
            #1;
            if (i == 0) in_valid = 0;
        end
        @(negedge clk);
        chk("drain_idle", out_valid, 0);
        @(posedge clk);
        #1 out_ready = 0;
        send(0, 127, 48'h400000000000, 0, 0, 0);
        send(0, 128, 48'h400000000000, 0, 0, 0);
        reset = 0;
        @(negedge clk);
        chk("rst_ready", in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        reset = 1;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_result_%0d", i), out_valid, 0);
        end
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
